// File: rtl/mem_dma.sv
// mem_dma: byte block-transfer engine that borrows mem_ctrl's read/write ports from the CPU.
// Optional fill mode is compiled in with `define MEM_DMA_FILL_EN.
module mem_dma #(
  parameter logic [7:0] PROT_LIMIT = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [7:0] len,
  input  logic       mode,
  input  logic [7:0] fill_value,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       prot_err,
  output logic       cpu_stall,
  input  logic [7:0] cpu_readaddr,
  input  logic [7:0] cpu_writeaddr,
  input  logic [7:0] cpu_writedata,
  input  logic       cpu_write_en,
  input  logic       pause_in,
  output logic [7:0] mem_readaddr,
  output logic [7:0] mem_writeaddr,
  output logic [7:0] mem_writedata,
  output logic       mem_write_en,
  output logic       mem_pause,
  input  logic [7:0] mem_readdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [7:0] rc_q, rc_d, wc_q, wc_d;
  logic       mode_q, mode_d;
  logic       wvld_q, wvld_d;
  logic       abort_q, abort_d;
  logic       prot_err_q, prot_err_d;
  logic       accept, fill_sel, rd_go, wr_go, wr_prot;
  logic [7:0] dma_raddr, dma_waddr;

`ifdef MEM_DMA_FILL_EN
  assign fill_sel = mode_q;
`else
  logic unused_fill;
  assign fill_sel    = 1'b0;
  assign unused_fill = &{1'b0, mode_q, fill_value};
`endif

  assign accept    = (state_q == S_IDLE) && start;
  assign dma_raddr = src_q + rc_q;
  assign dma_waddr = dst_q + wc_q;
  assign wr_prot   = (dma_waddr < PROT_LIMIT);
  assign rd_go     = (state_q == S_RUN) && !fill_sel && (rc_q < len_q);
  // Copy writes trail reads by one cycle (mem_ctrl read latency); fill writes need no read.
  assign wr_go     = (state_q == S_RUN) && (fill_sel ? (wc_q < len_q) : wvld_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    src_q  <= src_d;
    dst_q  <= dst_d;
    len_q  <= len_d;
    mode_q <= mode_d;
    if (reset) begin
      rc_q       <= 8'd0;
      wc_q       <= 8'd0;
      wvld_q     <= 1'b0;
      abort_q    <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      rc_q       <= rc_d;
      wc_q       <= wc_d;
      wvld_q     <= wvld_d;
      abort_q    <= abort_d;
      prot_err_q <= prot_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (len == 8'd0) ? S_DONE : S_RUN;
      S_RUN:  if (abort || (wc_d == len_q)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    mode_d     = mode_q;
    rc_d       = rc_q;
    wc_d       = wc_q;
    wvld_d     = 1'b0;
    abort_d    = abort_q;
    prot_err_d = prot_err_q;
    if (accept) begin
      src_d      = src;
      dst_d      = dst;
      len_d      = len;
      mode_d     = mode;
      rc_d       = 8'd0;
      wc_d       = 8'd0;
      abort_d    = 1'b0;
      prot_err_d = 1'b0;
    end else if (state_q == S_RUN) begin
      if (rd_go) rc_d = rc_q + 8'd1;
      if (wr_go) wc_d = wc_q + 8'd1;
      wvld_d = rd_go && !abort;
      if (abort) abort_d = 1'b1;
      if (wr_go && wr_prot) prot_err_d = 1'b1;
    end
  end

  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    aborted   = (state_q == S_DONE) && abort_q;
    prot_err  = prot_err_q;
    cpu_stall = busy;
    mem_pause = pause_in && !busy;
    if (busy) begin
      mem_readaddr  = dma_raddr;
      mem_writeaddr = dma_waddr;
      mem_writedata = fill_sel ? fill_value : mem_readdata;
      // Protected destinations and the reset cycle never reach the RAM.
      mem_write_en  = wr_go && !wr_prot && !reset;
    end else begin
      mem_readaddr  = cpu_readaddr;
      mem_writeaddr = cpu_writeaddr;
      mem_writedata = cpu_writedata;
      mem_write_en  = cpu_write_en;
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a small RAM model (one-cycle read latency, same-cycle write bypass).
module tb_mem_dma;

  logic       clk = 1'b0;
  logic       reset, start, mode, abort;
  logic [7:0] src, dst, len, fill_value;
  logic       busy, done, aborted, prot_err, cpu_stall;
  logic [7:0] cpu_readaddr, cpu_writeaddr, cpu_writedata;
  logic       cpu_write_en, pause_in;
  logic [7:0] mem_readaddr, mem_writeaddr, mem_writedata, mem_readdata;
  logic       mem_write_en, mem_pause;

  logic [7:0] ram [256];
  int tests_run = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_dma dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .mode(mode), .fill_value(fill_value), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .prot_err(prot_err), .cpu_stall(cpu_stall),
    .cpu_readaddr(cpu_readaddr), .cpu_writeaddr(cpu_writeaddr), .cpu_writedata(cpu_writedata),
    .cpu_write_en(cpu_write_en), .pause_in(pause_in),
    .mem_readaddr(mem_readaddr), .mem_writeaddr(mem_writeaddr), .mem_writedata(mem_writedata),
    .mem_write_en(mem_write_en), .mem_pause(mem_pause), .mem_readdata(mem_readdata)
  );

  always @(posedge clk) begin
    if (mem_write_en) ram[mem_writeaddr] <= mem_writedata;
    if (mem_write_en && (mem_writeaddr == mem_readaddr)) mem_readdata <= mem_writedata;
    else mem_readdata <= ram[mem_readaddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    cpu_writeaddr = a; cpu_writedata = v; cpu_write_en = 1'b1;
    @(negedge clk);
    cpu_write_en = 1'b0;
  endtask

  // Cycle 0 is the start cycle; inputs change on negedge and outputs are sampled 1 time unit later.
  task automatic xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                      input logic m, input logic [7:0] fv,
                      input int abort_cyc, input int reset_cyc, input int restart_cyc,
                      output int done_cyc, output int stall_cyc, output int wr_cnt,
                      output int last_wr, output int end_cyc, output logic abt, output int pause_bad);
    done_cyc = -1; stall_cyc = 0; wr_cnt = 0; last_wr = -1; end_cyc = -1; abt = 1'b0; pause_bad = 0;
    @(negedge clk);
    src = s; dst = d; len = l; mode = m; fill_value = fv; start = 1'b1; pause_in = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      abort = (c == abort_cyc);
      reset = (c == reset_cyc);
      #1;
      if (busy) stall_cyc++;
      if (busy && mem_write_en) begin wr_cnt++; last_wr = c; end
      if (busy && mem_pause) pause_bad++;
      if (done) begin done_cyc = c; abt = aborted; end
      end_cyc = c;
      if (done || ((reset_cyc >= 0) && (c > reset_cyc) && !busy)) break;
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; reset = 1'b0; pause_in = 1'b0;
  endtask

  int dc, sc, wc, lw, ec, pb;
  logic ab;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    src = 8'h0; dst = 8'h0; len = 8'h0; fill_value = 8'h0;
    cpu_readaddr = 8'h0; cpu_writeaddr = 8'h0; cpu_writedata = 8'h0;
    cpu_write_en = 1'b0; pause_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_prot_err", prot_err, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_mem_we", mem_write_en, 0);
    @(negedge clk);
    reset = 1'b0; cpu_readaddr = 8'h5C; pause_in = 1'b1;
    #1;
    check("idle_raddr_pass", mem_readaddr, 8'h5C);
    check("idle_pause_pass", mem_pause, 1);
    pause_in = 1'b0;

    // Basic copy
    poke(8'h20, 8'hA1); poke(8'h21, 8'hB2); poke(8'h22, 8'hC3); poke(8'h23, 8'hD4);
    poke(8'h24, 8'hE5); poke(8'h25, 8'hE6); poke(8'h26, 8'hE7); poke(8'h27, 8'hE8);
    xfer(8'h20, 8'h40, 8'd4, 1'b0, 8'h00, -1, -1, -1, dc, sc, wc, lw, ec, ab, pb);
    check("copy_done_cyc", dc, 6);
    check("copy_stall", sc, 5);
    check("copy_wr_cnt", wc, 4);
    check("copy_last_wr", lw, 5);
    check("copy_pause_low", pb, 0);
    check("copy_prot_err", prot_err, 0);
    check("copy_m40", ram[8'h40], 8'hA1);
    check("copy_m41", ram[8'h41], 8'hB2);
    check("copy_m42", ram[8'h42], 8'hC3);
    check("copy_m43", ram[8'h43], 8'hD4);

    // Protected destination
    poke(8'h30, 8'h11); poke(8'h31, 8'h22); poke(8'h32, 8'h33); poke(8'h33, 8'h44);
    poke(8'h0E, 8'h5E); poke(8'h0F, 8'h5F);
    xfer(8'h30, 8'h0E, 8'd4, 1'b0, 8'h00, -1, -1, -1, dc, sc, wc, lw, ec, ab, pb);
    check("prot_err_set", prot_err, 1);
    check("prot_wr_cnt", wc, 2);
    check("prot_m0e", ram[8'h0E], 8'h5E);
    check("prot_m0f", ram[8'h0F], 8'h5F);
    check("prot_m10", ram[8'h10], 8'h33);
    check("prot_m11", ram[8'h11], 8'h44);

    // Source wrap 0xFF -> 0x00
    poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03);
    xfer(8'hFE, 8'h50, 8'd3, 1'b0, 8'h00, -1, -1, -1, dc, sc, wc, lw, ec, ab, pb);
    check("wrap_prot_cleared", prot_err, 0);
    check("wrap_m50", ram[8'h50], 8'h01);
    check("wrap_m51", ram[8'h51], 8'h02);
    check("wrap_m52", ram[8'h52], 8'h03);

    // Forward overlap replicates the leading byte
    poke(8'h60, 8'h5A); poke(8'h61, 8'h00); poke(8'h62, 8'h00); poke(8'h63, 8'h00);
    xfer(8'h60, 8'h61, 8'd3, 1'b0, 8'h00, -1, -1, -1, dc, sc, wc, lw, ec, ab, pb);
    check("ovl_m61", ram[8'h61], 8'h5A);
    check("ovl_m62", ram[8'h62], 8'h5A);
    check("ovl_m63", ram[8'h63], 8'h5A);

    // Zero length
    xfer(8'h20, 8'h40, 8'd0, 1'b0, 8'h00, -1, -1, -1, dc, sc, wc, lw, ec, ab, pb);
    check("len0_done_cyc", dc, 1);
    check("len0_stall", sc, 0);
    check("len0_wr_cnt", wc, 0);

    // start while busy is ignored
    xfer(8'h20, 8'h48, 8'd4, 1'b0, 8'h00, -1, -1, 2, dc, sc, wc, lw, ec, ab, pb);
    #1;
    check("restart_done_cyc", dc, 6);
    check("restart_idle_after", busy, 0);
    check("restart_m48", ram[8'h48], 8'hA1);
    check("restart_m4b", ram[8'h4B], 8'hD4);

    // Abort in cycle 2
    poke(8'hA0, 8'h00); poke(8'hA1, 8'h00);
    xfer(8'h20, 8'hA0, 8'd8, 1'b0, 8'h00, 2, -1, -1, dc, sc, wc, lw, ec, ab, pb);
    check("abort_done_cyc", dc, 3);
    check("abort_flag", ab, 1);
    check("abort_wr_cnt", wc, 1);
    check("abort_last_wr", lw, 2);
    check("abort_mA0", ram[8'hA0], 8'hA1);
    check("abort_mA1", ram[8'hA1], 8'h00);

    // Reset in cycle 3, then a full transfer
    poke(8'hB0, 8'h00); poke(8'hB1, 8'h00);
    xfer(8'h20, 8'hB0, 8'd8, 1'b0, 8'h00, -1, 3, -1, dc, sc, wc, lw, ec, ab, pb);
    check("rstmid_end_cyc", ec, 4);
    check("rstmid_no_done", dc, -1);
    check("rstmid_wr_cnt", wc, 1);
    check("rstmid_mB1", ram[8'hB1], 8'h00);
    xfer(8'h20, 8'hB0, 8'd8, 1'b0, 8'h00, -1, -1, -1, dc, sc, wc, lw, ec, ab, pb);
    check("rerun_done_cyc", dc, 10);
    check("rerun_not_aborted", ab, 0);
    check("rerun_wr_cnt", wc, 8);
    check("rerun_mB1", ram[8'hB1], 8'hB2);
    check("rerun_mB7", ram[8'hB7], 8'hE8);

    // Fill request (copy when fill support is not compiled in)
    xfer(8'h20, 8'h70, 8'd2, 1'b1, 8'hEE, -1, -1, -1, dc, sc, wc, lw, ec, ab, pb);
`ifdef MEM_DMA_FILL_EN
    check("fill_done_cyc", dc, 3);
    check("fill_stall", sc, 2);
    check("fill_m70", ram[8'h70], 8'hEE);
    check("fill_m71", ram[8'h71], 8'hEE);
`else
    check("fill_off_done_cyc", dc, 4);
    check("fill_off_stall", sc, 3);
    check("fill_off_m70", ram[8'h70], 8'hA1);
    check("fill_off_m71", ram[8'h71], 8'hB2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Block-transfer engine in front of `mem_ctrl`'s read and write ports. On a `start` pulse it takes ownership of both ports and stalls the CPU pipeline. It then copies `len` bytes from `src` to `dst` in the current bank at one byte per cycle. When the copy finishes it returns the ports to the CPU. It sits between the CPU datapath and `mem_ctrl` and muxes addresses, data and write enable.

## Interface
Parameters:
- `PROT_LIMIT`, default 8'h10: destination addresses below this value are never written. This covers the special registers, the indirect registers and IO.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `src`, `dst`, `len`  in  8 each  transfer parameters, latched when `start` is accepted
- `mode`  in  1  0 = copy, 1 = fill (see Configuration)
- `fill_value`  in  8  byte written in fill mode
- `abort`  in  1  stop the transfer; takes effect at the next edge
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse
- `aborted`  out  1  valid with `done`; high if the transfer ended by `abort`
- `prot_err`  out  1  sticky; at least one write was suppressed by `PROT_LIMIT`; cleared on `start` accept
- `cpu_stall`  out  1  freezes the CPU pipeline; equals `busy`
- `cpu_readaddr`, `cpu_writeaddr`, `cpu_writedata`  in  8 each  CPU-side port signals
- `cpu_write_en`  in  1  CPU-side write enable
- `pause_in`  in  1  CPU pause request
- `mem_readaddr`, `mem_writeaddr`, `mem_writedata`  out  8 each  to `mem_ctrl`
- `mem_write_en`  out  1  to `mem_ctrl`
- `mem_pause`  out  1  to `mem_ctrl`; equals `pause_in & ~busy`
- `mem_readdata`  in  8  from `mem_ctrl`; one-cycle read latency

## Operation
States:
- **IDLE**
  - Ports pass through from the CPU side; `busy` = 0.
  - `start` latches `src`, `dst`, `len` and `mode`, clears `prot_err`, and moves to RUN.
  - `start` with `len` = 0 goes directly to DONE with no memory access.
- **RUN**
  - Read counter `rc` and write counter `wc` start at 0.
  - Each cycle with `rc` < `len`: drive `mem_readaddr` = `src` + `rc`, then `rc` increments.
  - Each cycle with the write-valid flag set (a read was issued in the previous cycle): drive `mem_writeaddr` = `dst` + `wc`, `mem_writedata` = `mem_readdata`, `mem_write_en` = 1, then `wc` increments.
  - When `wc` reaches `len`, move to DONE.
- **DONE**
  - One cycle: `done` = 1, `busy` = 0, ports back on the CPU side; return to IDLE.

Rules:
- CPU writes are dropped (`mem_write_en` takes the DMA value) whenever `busy` = 1.
- Address arithmetic is 8-bit and wraps from 0xFF to 0x00.
- A write to an address below `PROT_LIMIT` has its `mem_write_en` forced to 0 and sets `prot_err`. The counters still advance.
- Forward copy only. Overlap with `dst` in (`src`, `src`+`len`) replicates the leading bytes; this is the defined behaviour, made consistent by `mem_ctrl`'s same-cycle bypass.
- `start` while `busy` is ignored.
- `abort` in RUN: no new reads or writes from the next edge onward; go to DONE with `aborted` = 1.
- `abort` and `start` together in IDLE: `start` wins and `abort` is ignored.
- `reset` in any state: IDLE, all counters cleared, no write in the reset cycle.
  - Reset values: `busy`, `done`, `aborted`, `prot_err`, `cpu_stall` and `mem_write_en` (DMA side) are 0.

## Timing
- Copy of length L:
  - `start` accepted in cycle 0.
  - Reads in cycles 1..L.
  - Writes in cycles 2..L+1.
  - `done` in cycle L+2.
  - `busy`/`cpu_stall` high in cycles 1..L+1, i.e. L+1 stall cycles.
- Fill of length L: writes in cycles 1..L, `done` in cycle L+1, L stall cycles.
- `mem_pause` is forced low while busy so that `mem_ctrl` sync registers and RAM keep advancing.
- Bank is not switched by the DMA; `status[6:5]` as of `start` applies throughout.

## Configuration
- `MEM_DMA_FILL_EN`:
  - Defined: `mode` = 1 selects fill. No reads are issued; `mem_writedata` = `fill_value` and writes start in cycle 1.
  - Undefined: the `mode` and `fill_value` ports exist but are ignored, and every transfer is a copy.

## Test plan
- Copy: preload 0x20..0x23 = {A1,B2,C3,D4}; `start` with `src`=0x20, `dst`=0x40, `len`=4 -> 0x40..0x43 = {A1,B2,C3,D4}; `done` in cycle 6; `cpu_stall` high exactly 5 cycles; `prot_err` = 0.
- Protection: `src`=0x30, `dst`=0x0E, `len`=4 -> no write at 0x0E or 0x0F; 0x10 and 0x11 written; `prot_err` = 1; `status`/`intcon` unchanged.
- Wrap and overlap:
  - `src`=0xFE, `dst`=0x50, `len`=3 -> reads from 0xFE, 0xFF, 0x00.
  - Overlap: `src`=0x60 = 0x5A, `dst`=0x61, `len`=3 -> 0x61..0x63 = 5A.
- Boundary controls:
  - `len`=0 -> `done` in cycle 1 with no `mem_write_en`.
  - `start` while busy -> ignored.
  - `abort` in cycle 2 of an `len`=8 copy -> `aborted` = 1 and no writes after cycle 2.
- Reset mid-transfer: `reset` in cycle 3 of an `len`=8 copy -> `busy` = 0 next cycle, no further writes; the next `start` runs a full transfer.
- Fill (macro defined): `mode`=1, `fill_value`=0xEE, `dst`=0x70, `len`=2 -> 0x70..0x71 = EE; `done` in cycle 3. With the macro undefined, the same stimulus performs a copy.
